// File: rtl/tt_um_accelshark_psg_dac_if.sv
// Voice-mix input bus and PDM/sample output bundle for the PSG output DAC stage.
// master drives voices and controls; slave is the DAC itself.
interface tt_um_accelshark_psg_dac_if #(
   parameter int VOICES = 4
);
   logic                  ena;
   logic                  mute;
   logic [5*VOICES-1:0]   mix_l_bus;
   logic [5*VOICES-1:0]   mix_r_bus;
   logic                  pdm_l;
   logic                  pdm_r;
   logic [7:0]            sample_l;
   logic [7:0]            sample_r;
   logic                  sample_tick;

   modport master (
      output ena, mute, mix_l_bus, mix_r_bus,
      input  pdm_l, pdm_r, sample_l, sample_r, sample_tick
   );

   modport slave (
      input  ena, mute, mix_l_bus, mix_r_bus,
      output pdm_l, pdm_r, sample_l, sample_r, sample_tick
   );
endinterface

// File: rtl/tt_um_accelshark_psg_dac.sv
// PSG output stage: per-channel voice sum, sample-rate latch, first-order delta-sigma PDM.
// Optional mute fade ramp is compiled in with `define PSG_DAC_MUTE_RAMP_EN.
module tt_um_accelshark_psg_dac #(
   parameter int VOICES     = 4,
   parameter int SAMPLE_DIV = 64
) (
   input  logic                          oclk,
   input  logic                          rst_n,
   tt_um_accelshark_psg_dac_if.slave     bus
);
   localparam int              DIV_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   logic signed [7:0] field_l [VOICES];
   logic signed [7:0] field_r [VOICES];
   logic signed [7:0] sum_l, sum_r;
   logic signed [7:0] scaled_l, scaled_r;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [7:0]       sample_l_q, sample_l_d, sample_r_q, sample_r_d;
   logic [7:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic             pdm_l_q, pdm_l_d, pdm_r_q, pdm_r_d;
   logic             tick_q, tick_d;
   logic             latch;
   logic [8:0]       mod_l, mod_r;

   generate
      for (genvar gi = 0; gi < VOICES; gi++) begin : g_field
         assign field_l[gi] = {{3{bus.mix_l_bus[5*gi+4]}}, bus.mix_l_bus[5*gi +: 5]};
         assign field_r[gi] = {{3{bus.mix_r_bus[5*gi+4]}}, bus.mix_r_bus[5*gi +: 5]};
      end
   endgenerate

   // At most 8 voices of -16..15 always fits in 8 signed bits, so no saturation.
   always_comb begin
      sum_l = '0;
      sum_r = '0;
      for (int i = 0; i < VOICES; i++) begin
         sum_l = sum_l + field_l[i];
         sum_r = sum_r + field_r[i];
      end
   end

   assign latch = (div_cnt_q == DIV_LAST);

`ifdef PSG_DAC_MUTE_RAMP_EN
   logic [4:0]         gain_q, gain_d;
   logic signed [13:0] prod_l, prod_r;

   // Scale by the gain held before this latch's step; >>> floors toward -inf.
   assign prod_l   = sum_l * $signed({1'b0, gain_q});
   assign prod_r   = sum_r * $signed({1'b0, gain_q});
   assign scaled_l = 8'(prod_l >>> 4);
   assign scaled_r = 8'(prod_r >>> 4);

   always_comb begin
      gain_d = gain_q;
      if (latch) begin
         if (bus.mute) begin
            if (gain_q != 5'd0) gain_d = gain_q - 5'd1;
         end else if (gain_q != 5'd16) begin
            gain_d = gain_q + 5'd1;
         end
      end
   end

   always_ff @(posedge oclk or negedge rst_n) begin
      if (!rst_n)       gain_q <= 5'd0;
      else if (bus.ena) gain_q <= gain_d;
   end
`else
   assign scaled_l = bus.mute ? 8'sd0 : sum_l;
   assign scaled_r = bus.mute ? 8'sd0 : sum_r;
`endif

   // The modulator always steps with the currently held sample, so a new sample
   // first influences the PDM one edge after sample_tick.
   assign mod_l = {1'b0, acc_l_q} + {1'b0, sample_l_q};
   assign mod_r = {1'b0, acc_r_q} + {1'b0, sample_r_q};

   always_comb begin
      div_cnt_d  = latch ? '0 : div_cnt_q + DIV_W'(1);
      sample_l_d = sample_l_q;
      sample_r_d = sample_r_q;
      tick_d     = latch;
      if (latch) begin
         sample_l_d = {~scaled_l[7], scaled_l[6:0]};
         sample_r_d = {~scaled_r[7], scaled_r[6:0]};
      end
      {pdm_l_d, acc_l_d} = mod_l;
      {pdm_r_d, acc_r_d} = mod_r;
   end

   always_ff @(posedge oclk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q  <= '0;
         sample_l_q <= 8'h80;
         sample_r_q <= 8'h80;
         acc_l_q    <= 8'h00;
         acc_r_q    <= 8'h00;
         pdm_l_q    <= 1'b0;
         pdm_r_q    <= 1'b0;
         tick_q     <= 1'b0;
      end else if (bus.ena) begin
         div_cnt_q  <= div_cnt_d;
         sample_l_q <= sample_l_d;
         sample_r_q <= sample_r_d;
         acc_l_q    <= acc_l_d;
         acc_r_q    <= acc_r_d;
         pdm_l_q    <= pdm_l_d;
         pdm_r_q    <= pdm_r_d;
         tick_q     <= tick_d;
      end
   end

   assign bus.pdm_l       = pdm_l_q;
   assign bus.pdm_r       = pdm_r_q;
   assign bus.sample_l    = sample_l_q;
   assign bus.sample_r    = sample_r_q;
   assign bus.sample_tick = tick_q;
endmodule
